// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Pure declarations: no logic, no latency, no flow control.
// Operand width is fixed by the shared 8-bit adder.
package adder_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_arb_if.sv
// Request/response bundle between requesting datapaths and the adder arbiter.
// Wires only: no latency; req_ready and rsp_ready carry the backpressure.
// master = requester/consumer side, slave = arbiter side.
interface adder_arb_if
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_sum;
    logic [IDX_W-1:0]          rsp_id;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

endinterface

// File: rtl/multibit_adder.sv
// Unsigned W-bit adder, carry discarded.
// Combinational, zero latency; no flow control.
// Shared resource: only the arbiter drives its inputs.
module multibit_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out
);

    assign out = a + b;

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first valid bit at or above rr_ptr, wrapping to 0.
// Purely combinational, zero latency; no backpressure of its own.
// Wrap compares against NUM_REQ-1 so non-power-of-two counts work.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && valid[cand]) begin
                any_valid = 1'b1;
                idx       = cand;
            end
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
        end
        if (any_valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin share of one adder among NUM_REQ requesters; ADDER_ARB_SATURATE_EN clamps overflow to 8'hFF.
// Accept in T, rsp_valid in T+2; one op in flight, issue interval >= 3 cycles.
// Holds RESP until rsp_ready; req_ready stays low while busy.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    adder_arb_if.slave  bus
);

    if (IDX_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_chk
        $error("adder_arbiter: NUM_REQ must be 2..8 and IDX_W must equal clog2(NUM_REQ)");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               rsp_vld_q, rsp_vld_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  add_out;
    logic [DATA_W-1:0]  calc_sum;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid     (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_gnt),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    multibit_adder #(
        .W (DATA_W)
    ) u_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .out (add_out)
    );

`ifdef ADDER_ARB_SATURATE_EN
    // A wrapped sum is always smaller than either operand.
    assign calc_sum = (add_out < op_a_q) ? '1 : add_out;
`else
    assign calc_sum = add_out;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sum_d     = sum_q;
        id_d      = id_q;
        rsp_vld_d = rsp_vld_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    op_a_d   = bus.req_a[pick_idx*DATA_W +: DATA_W];
                    op_b_d   = bus.req_b[pick_idx*DATA_W +: DATA_W];
                    gnt_id_d = pick_idx;
                    state_d  = CALC;
                end
            end
            CALC: begin
                sum_d     = calc_sum;
                id_d      = gnt_id_q;
                rsp_vld_d = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    rr_ptr_d  = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_id_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
            id_q      <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_id_q  <= gnt_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sum_q     <= sum_d;
            id_q      <= id_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // Grant is combinational, so it must also be masked while reset is held.
    assign bus.req_ready = (state_q == IDLE && !reset) ? pick_gnt : '0;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed checks of adder_arbiter against a queue-free arithmetic model.
// Model keeps only the round-robin pointer and computes grants/sums from plain arithmetic.
module tb_adder_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;

    adder_arb_if #(.NUM_REQ(N), .IDX_W(2)) bus ();

    adder_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int mptr  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef ADDER_ARB_SATURATE_EN
        if (s > 255) return 8'hFF;
`endif
        return 8'(s % 256);
    endfunction

    // Starts and ends just after a rising edge with the DUT idle.
    task automatic run_op(input logic [N-1:0] vld, input logic [31:0] a_bus,
                          input logic [31:0] b_bus, input int hold);
        int         g;
        logic [7:0] es;
        logic [N-1:0] oh;
        g = model_pick(vld);
        bus.req_valid = vld;
        bus.req_a     = a_bus;
        bus.req_b     = b_bus;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        check_eq("idle_busy", 32'(bus.busy), 0);
        check_eq("idle_rsp_valid", 32'(bus.rsp_valid), 0);
        if (g < 0) begin
            check_eq("no_req_ready", 32'(bus.req_ready), 0);
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            return;
        end
        oh = N'(1 << g);
        check_eq("grant", 32'(bus.req_ready), 32'(oh));
        es = model_sum(int'(a_bus[g*8 +: 8]), int'(b_bus[g*8 +: 8]));

        @(posedge clk); #1;
        bus.req_valid = vld & ~oh;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        check_eq("calc_req_ready", 32'(bus.req_ready), 0);
        check_eq("calc_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("calc_busy", 32'(bus.busy), 1);

        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        #1;
        check_eq("rsp_valid", 32'(bus.rsp_valid), 1);
        check_eq("rsp_sum", 32'(bus.rsp_sum), 32'(es));
        check_eq("rsp_id", 32'(bus.rsp_id), 32'(g));
        check_eq("rsp_req_ready", 32'(bus.req_ready), 0);
        check_eq("rsp_busy", 32'(bus.busy), 1);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1; #1;
            check_eq("hold_valid", 32'(bus.rsp_valid), 1);
            check_eq("hold_sum", 32'(bus.rsp_sum), 32'(es));
            check_eq("hold_id", 32'(bus.rsp_id), 32'(g));
            check_eq("hold_req_ready", 32'(bus.req_ready), 0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        #1;
        check_eq("release_valid", 32'(bus.rsp_valid), 0);
        check_eq("release_busy", 32'(bus.busy), 0);
        mptr = (g + 1) % N;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 0);
        check_eq("rst_sum", 32'(bus.rsp_sum), 0);
        check_eq("rst_id", 32'(bus.rsp_id), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single request, 0 + 1 from requester 0.
        run_op(4'b0001, 32'h0000_0000, 32'h0000_0001, 0);

        // Abort an op in CALC; pointer must fall back to 0.
        bus.req_valid = 4'hF;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        #1;
        check_eq("abort_grant", 32'(bus.req_ready), 32'(1 << model_pick(4'hF)));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1; #1;
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("abort_busy", 32'(bus.busy), 0);
        check_eq("abort_sum", 32'(bus.rsp_sum), 0);
        check_eq("abort_id", 32'(bus.rsp_id), 0);
        check_eq("abort_req_ready", 32'(bus.req_ready), 0);
        reset         = 1'b0;
        bus.req_valid = '0;
        mptr          = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; #1;
            check_eq("abort_no_rsp", 32'(bus.rsp_valid), 0);
        end

        // Fairness: all valid, requester i sends i + 10.
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, {4{8'd10}}, 0);
        end

        // Backpressure on requester 1.
        run_op(4'b0010, {8'd0, 8'd0, 8'd20, 8'd0}, {8'd0, 8'd0, 8'd22, 8'd0}, 5);

        // Pointer skip: serve 0, then 3, then 0 again.
        run_op(4'b0001, 32'h0000_0005, 32'h0000_0006, 0);
        run_op(4'b1001, {8'd7, 8'd0, 8'd0, 8'd1}, {8'd8, 8'd0, 8'd0, 8'd2}, 0);
        run_op(4'b1001, {8'd7, 8'd0, 8'd0, 8'd1}, {8'd8, 8'd0, 8'd0, 8'd2}, 1);

        // Overflow and the largest non-overflowing case.
        run_op(4'b0100, {8'd0, 8'd200, 8'd0, 8'd0}, {8'd0, 8'd100, 8'd0, 8'd0}, 0);
        run_op(4'b0100, {8'd0, 8'd255, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
